// File: rtl/fa_pkg.sv
// fa_pkg: shared definitions for the result path.
//   state_t           - result_packer FSM state encoding
//   FP16_W / WORD_W   - engine result width and FIFO word width
//   RESULT_BLOCK_SIZE - FIFO words per host pipe-out block (512 B / 4)
package fa_pkg;

  localparam int FP16_W            = 16;
  localparam int WORD_W            = 32;
  localparam int RESULT_BLOCK_SIZE = 128;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_FLUSH = 3'd3,
    S_PAD   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/result_packer.sv
// result_packer: packs two fp16 engine results into each 32-bit result FIFO
// word (first result in [15:0], second in [31:16]), backpressures the engine
// on FIFO full, flushes a trailing half-word at end of layer and pulses done.
//
// Optional feature: define RESULT_PAD_EN to zero-fill the layer up to a whole
// number of BLOCK_SIZE-word host blocks.
//
// Ports:
//   clk          sys_clk, rising edge
//   rst          async active-high reset
//   start        one-cycle pulse, arms a new layer (ignored while busy)
//   in_valid     engine result valid
//   in_data      fp16 result
//   in_last      final result of the layer
//   in_ready     result accepted this cycle when in_valid is also high
//   fifo_full    result FIFO full flag
//   fifo_wr_en   FIFO write strobe (never asserted while full)
//   fifo_din     FIFO write data
//   word_count   words written this layer, saturating
//   done         one-cycle pulse after the last write of the layer
//   busy         high from the cycle after start through the done cycle
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | waiting for start
// S_LO    | awaiting the low half of the next word
// S_HI    | awaiting the high half of the current word
// S_FLUSH | draining the final word of the layer
// S_PAD   | writing zero words until the block boundary
// S_DONE  | done pulse, back to idle next cycle
module result_packer
  import fa_pkg::*;
#(
  parameter int BLOCK_SIZE = RESULT_BLOCK_SIZE,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [FP16_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_din,
  output logic [CNT_W-1:0]  word_count,
  output logic              done,
  output logic              busy
);

  // The block counter is log2(BLOCK_SIZE) bits wide and wraps naturally.
  if (BLOCK_SIZE < 2 || (BLOCK_SIZE & (BLOCK_SIZE - 1)) != 0) begin : g_bad_block_size
    $error("result_packer: BLOCK_SIZE must be a power of two >= 2");
  end

  state_t state, state_nxt;
  logic   pending;
  logic   accept;

  assign accept = in_valid && in_ready;

`ifdef RESULT_PAD_EN
  localparam int BLK_W = $clog2(BLOCK_SIZE);
  logic [BLK_W-1:0] blk_cnt, blk_cnt_nxt;

  always_comb begin
    blk_cnt_nxt = blk_cnt;
    if (fifo_wr_en) blk_cnt_nxt = blk_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          blk_cnt <= '0;
    else if (state == S_IDLE && start) blk_cnt <= '0;
    else                              blk_cnt <= blk_cnt_nxt;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LO;
      S_LO:    if (accept) state_nxt = in_last ? S_FLUSH : S_HI;
      S_HI:    if (accept) state_nxt = in_last ? S_FLUSH : S_LO;
      S_FLUSH: begin
        // Leave in the cycle the final word is written so done lands one
        // cycle after that write.
        if (fifo_wr_en || !pending) begin
`ifdef RESULT_PAD_EN
          state_nxt = (blk_cnt_nxt != '0) ? S_PAD : S_DONE;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef RESULT_PAD_EN
      S_PAD:   if (fifo_wr_en && blk_cnt_nxt == '0) state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    fifo_wr_en = pending && !fifo_full;
    in_ready   = (state == S_LO || state == S_HI) && !(pending && fifo_full);
    done       = (state == S_DONE);
    busy       = (state != S_IDLE);
  end

  // Output word register and layer word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_din   <= '0;
      pending    <= 1'b0;
      word_count <= '0;
    end else if (state == S_IDLE && start) begin
      fifo_din   <= '0;
      pending    <= 1'b0;
      word_count <= '0;
    end else begin
      if (fifo_wr_en) begin
        pending <= 1'b0;
        if (word_count != '1) word_count <= word_count + 1'b1;
      end
      case (state)
        S_LO: begin
          // A low half may land while the previous word is being written;
          // the write uses the current register contents.
          if (accept) begin
            fifo_din[FP16_W-1:0] <= in_data;
            if (in_last) begin
              fifo_din[WORD_W-1:FP16_W] <= '0;
              pending                   <= 1'b1;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            fifo_din[WORD_W-1:FP16_W] <= in_data;
            pending                   <= 1'b1;
          end
        end
`ifdef RESULT_PAD_EN
        S_FLUSH: begin
          if (state_nxt == S_PAD) begin
            fifo_din <= '0;
            pending  <= 1'b1;
          end
        end
        S_PAD: begin
          if (fifo_wr_en && blk_cnt_nxt != '0) pending <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: directed test of result_packer with a word-level
// scoreboard. Accepted results are paired into expected FIFO words (zero
// pad words appended at end of layer when RESULT_PAD_EN is defined); a
// negedge monitor checks every write, word_count, busy, done timing and the
// never-write-while-full rule. Literal checks pin the scoreboard per test.
module tb_result_packer;
  import fa_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic [15:0] word_count;
  logic        done;
  logic        busy;

  result_packer #(.BLOCK_SIZE(128), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .word_count(word_count), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef RESULT_PAD_EN
  localparam int WC_A = 128, WC_B = 128, WC_C = 128, WC_P = 128, WC_R = 128, WC_S = 128;
`else
  localparam int WC_A = 2, WC_B = 2, WC_C = 2, WC_P = 65, WC_R = 1, WC_S = 2;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wlog[256];
  int          wn = 0;
  int          wc_m = 0;
  int          lw = 0;
  bit          busy_m = 0, done_due = 0, all_fed = 0, layer_done = 0, have_lo = 0;
  logic [15:0] lo_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      bit start_ok, nxt_done;
      start_ok = start && !busy_m;
      nxt_done = 0;
      chk("busy", busy, busy_m);
      chk("done", done, done_due);
      chk("word_count", word_count, wc_m);
      if (!busy_m) chk("ready_idle", in_ready, 1'b0);
      if (fifo_wr_en) begin
        chk("wr_while_full", fifo_full, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", fifo_din, 32'hxxxx_xxxx);
        end else begin
          chk("fifo_din", fifo_din, exp_q.pop_front());
        end
        if (wn < 256) wlog[wn] = fifo_din;
        wn++;
        if (wc_m < 65535) wc_m++;
        if (exp_q.size() == 0 && all_fed) nxt_done = 1;
      end
      if (done) begin
        busy_m     = 0;
        all_fed    = 0;
        layer_done = 1;
      end
      if (start_ok) begin
        busy_m = 1;
        wc_m   = 0;
      end
      done_due = nxt_done;
    end
  end

  task automatic model_accept(input logic [15:0] d, input bit last);
    if (have_lo) begin
      exp_q.push_back({d, lo_m});
      lw++;
      have_lo = 0;
    end else if (last) begin
      exp_q.push_back({16'h0000, d});
      lw++;
    end else begin
      lo_m    = d;
      have_lo = 1;
    end
    if (last) begin
`ifdef RESULT_PAD_EN
      while (lw % 128 != 0) begin
        exp_q.push_back(32'h0);
        lw++;
      end
`endif
      all_fed = 1;
    end
  endtask

  task automatic feed(input logic [15:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, last);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL feed_timeout: data %h not accepted within 200 cycles", d);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    lw = 0; have_lo = 0; wn = 0; layer_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 2000 && !layer_done; t++) @(posedge clk);
    #1;
    n_checks++;
    if (!layer_done) begin
      n_fail++;
      $display("FAIL done_timeout: done not seen within 2000 cycles");
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fifo_wr_en", fifo_wr_en, 0);
    chk("rst_fifo_din", fifo_din, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Four results, no stall
    do_start();
    feed(16'h0001, 0); feed(16'h0002, 0); feed(16'h0003, 0); feed(16'h0004, 1);
    idle_in();
    wait_done();
    chk("A_word0", wlog[0], 32'h0002_0001);
    chk("A_word1", wlog[1], 32'h0004_0003);
    chk("A_count", word_count, WC_A);
    chk("A_writes", wn, WC_A);

    // Three results, odd trailing half
    do_start();
    feed(16'h0001, 0); feed(16'h0002, 0); feed(16'h0003, 1);
    idle_in();
    wait_done();
    chk("B_word0", wlog[0], 32'h0002_0001);
    chk("B_word1", wlog[1], 32'h0000_0003);
    chk("B_count", word_count, WC_B);

    // FIFO full with a word pending for 10 cycles
    do_start();
    fifo_full = 1'b1;
    feed(16'h0011, 0); feed(16'h0022, 0);
    in_valid = 1'b1; in_data = 16'h0033; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("C_stall_ready", in_ready, 0);
      chk("C_stall_wr", fifo_wr_en, 0);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    feed(16'h0033, 0); feed(16'h0044, 1);
    idle_in();
    wait_done();
    chk("C_word0", wlog[0], 32'h0022_0011);
    chk("C_word1", wlog[1], 32'h0044_0033);
    chk("C_count", word_count, WC_C);

    // 130 results (65 words)
    do_start();
    for (int i = 0; i < 130; i++) feed(16'(i + 1), i == 129);
    idle_in();
    wait_done();
    chk("P_word0", wlog[0], 32'h0002_0001);
    chk("P_word64", wlog[64], 32'h0082_0081);
    chk("P_count", word_count, WC_P);
    chk("P_writes", wn, WC_P);
`ifdef RESULT_PAD_EN
    chk("P_pad_first", wlog[65], 32'h0);
    chk("P_pad_last", wlog[127], 32'h0);
`endif

    // Reset mid-layer after 5 results
    do_start();
    for (int i = 0; i < 5; i++) feed(16'(16'h0100 + i), 0);
    idle_in();
    rst = 1'b1;
    #1;
    chk("R_in_ready", in_ready, 0);
    chk("R_fifo_wr_en", fifo_wr_en, 0);
    chk("R_fifo_din", fifo_din, 0);
    chk("R_word_count", word_count, 0);
    chk("R_done", done, 0);
    chk("R_busy", busy, 0);
    exp_q.delete();
    wc_m = 0; busy_m = 0; done_due = 0; all_fed = 0; have_lo = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_start();
    feed(16'h000a, 0); feed(16'h000b, 1);
    idle_in();
    wait_done();
    chk("R_word0", wlog[0], 32'h000b_000a);
    chk("R_count", word_count, WC_R);
    chk("R_writes", wn, WC_R);

    // start while busy is ignored
    do_start();
    feed(16'h0021, 0); feed(16'h0022, 0);
    idle_in();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(16'h0023, 0); feed(16'h0024, 1);
    idle_in();
    wait_done();
    chk("S_word0", wlog[0], 32'h0022_0021);
    chk("S_word1", wlog[1], 32'h0024_0023);
    chk("S_count", word_count, WC_S);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
